fifo_upsize_wide: RTL and testbench
===================================

# fifo_upsize_wide

Parametrised narrow-to-wide up-sizing FIFO. It accepts one DATA_WIDTH-bit word per write and presents RATIO packed words as one wide read word. Each stored word carries a per-entry even-parity bit, and the block adds programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow/parity flags and a fill-level count. It sits between byte-oriented producers and 32/64-bit SoC consumers, generalising the fixed 8-to-32 FIFO.

## Interface
- DATA_WIDTH, 8: narrow (write) word width.
- RATIO, 4: narrow words per read word. Must be a power of 2 and ≤ DEPTH.
- ADDR_WIDTH, 4: narrow-entry address width.
- DEPTH, 2**ADDR_WIDTH: capacity in narrow entries.
- AF_THRESH, DEPTH-RATIO: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, RATIO: almost_empty asserts when count < AE_THRESH.
- READ_WIDTH, RATIO*DATA_WIDTH: read word width (derived).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- w_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- par_inject  in  1  when high with an accepted write, store inverted parity (test hook).
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- r_data  out  READ_WIDTH  head word, oldest narrow word in bits [DATA_WIDTH-1:0]; zero while empty.
- rd_en  in  1  read request.
- empty  out  1  count < RATIO.
- almost_empty  out  1  count < AE_THRESH.
- count  out  $clog2(DEPTH+1)  stored narrow entries.
- parity_error  out  1  combinational mismatch on any of the RATIO head entries; 0 while empty.
- flush  in  1  synchronous drop of all contents.
- err_clr  in  1  clears sticky flags.
- overflow  out  1  sticky: wr_en while full.
- underflow  out  1  sticky: rd_en while empty.
- parity_sticky  out  1  sticky: rd_fire while parity_error.

## Operation
- wr_fire = wr_en & !full. rd_fire = rd_en & !empty. full blocks writes even when rd_fire is high in the same cycle.
- Write: mem[wr_ptr] <= {(^w_data) ^ par_inject, w_data}. wr_ptr advances by 1 modulo DEPTH.
- Read: r_data = concatenation of mem[(rd_ptr+k) mod DEPTH] data fields, k=0 oldest at LSB. rd_ptr advances by RATIO modulo DEPTH. Wrap is natural because DEPTH is a multiple of RATIO.
- count next value:
  - wr_fire only: +1.
  - rd_fire only: −RATIO.
  - both: +1−RATIO.
  - neither: hold. Registers and memory do not toggle when idle.
- flush: wr_ptr, rd_ptr and count go to 0. Takes priority over wr_fire/rd_fire in the same cycle (neither takes effect). Sticky flags are not affected.
- Sticky flags: set on their event, cleared by err_clr. A set event in the same cycle as err_clr wins. overflow/underflow are evaluated on the raw wr_en/rd_en against the current flags.
- Elaboration: $error if RATIO is not a power of 2, if RATIO > DEPTH, or if AF_THRESH > DEPTH.

## Timing
- Reset (rst_n low, asynchronous): pointers and count = 0. Outputs:
  - full 0, empty 1, almost_empty 1.
  - almost_full = (AF_THRESH == 0).
  - r_data 0, parity_error 0.
  - overflow, underflow and parity_sticky 0.
- Memory is not reset.
- Reset deassertion is internally synchronised. The first write is accepted on the second rising edge after rst_n rises.
- Write latency: a word written at edge N is reflected in count/flags after edge N. A wide word completed at edge N is on r_data with empty low in the following cycle.
- Read is combinational (0-cycle): r_data and parity_error are valid whenever empty is low. rd_fire consumes the word at the edge.
- All flags are combinational from count. No registered lag.
- Reset asserted mid-operation discards all contents immediately. Stored data is lost.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 (defaults) -> empty drops after the 4th edge, r_data = 0x44332211, count = 4, parity_error 0; rd_en one cycle -> count 0, empty 1.
- Write 16 bytes with wr_en held 2 extra cycles -> full 1 and almost_full 1 at count 16; the extra writes are dropped; overflow 1 until err_clr.
- At count 16, wr_en and rd_en together -> read only: count 12, full 0. At count 8, both -> count 5.
- Fill, read 3 words, write 8 more so pointers wrap -> words are read back in order across the wrap boundary; count tracks exactly.
- par_inject on byte 2 of a word -> parity_error 1 while that word is at the head; rd_fire sets parity_sticky; next clean word shows parity_error 0.
- rd_en while empty -> underflow 1 and count unchanged. flush at count 7 with wr_en high -> count 0, no write. rst_n pulsed low mid-fill -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_upsize_wide.sv
`default_nettype none
// ============================================================================
// Module   : fifo_upsize_wide
// Function : Narrow-to-wide up-sizing FIFO. Accepts one DATA_WIDTH word per
//            write and presents RATIO packed words as one wide read word.
//            Per-entry even parity, almost-full/almost-empty thresholds,
//            synchronous flush, sticky error flags and fill-level count.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_upsize_wide #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int AF_THRESH  = DEPTH - RATIO,
    parameter int AE_THRESH  = RATIO,
    parameter int READ_WIDTH = RATIO * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic                         wr_en,
    input  logic                         par_inject,
    output logic                         full,
    output logic                         almost_full,
    output logic [READ_WIDTH-1:0]        r_data,
    input  logic                         rd_en,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         parity_error,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         parity_sticky
);

    localparam int                 c_cnt_w     = $clog2(DEPTH + 1);
    localparam int                 c_ent_w     = DATA_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_ratio_cnt = c_cnt_w'(RATIO);
    // RATIO == DEPTH truncates to 0, which is the correct modulo-DEPTH step
    localparam logic [ADDR_WIDTH-1:0] c_ratio_ptr = ADDR_WIDTH'(RATIO);

    // ------------------------------------------------------------------------
    // Parameter sanity checks
    // ------------------------------------------------------------------------
    if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0)) begin : g_chk_ratio_pow2
        $error("fifo_upsize_wide: RATIO must be a power of 2");
    end
    if (RATIO > DEPTH) begin : g_chk_ratio_depth
        $error("fifo_upsize_wide: RATIO must not exceed DEPTH");
    end
    if (AF_THRESH > DEPTH) begin : g_chk_af_thresh
        $error("fifo_upsize_wide: AF_THRESH must not exceed DEPTH");
    end

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [c_ent_w-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    w_count_nxt;
    logic                  r_run;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_parity_sticky;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_flush;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_par_set;
    logic [READ_WIDTH-1:0] w_head;
    logic [RATIO-1:0]      w_head_perr;
    logic                  w_parity_error;

    // Reset release is retimed to the clock: the core stays idle for the
    // first edge after rst_n rises so the first write lands on the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // ------------------------------------------------------------------------
    // Handshake qualification; full blocks writes even alongside a read
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_depth_cnt);
    assign w_empty   = (r_count <  c_ratio_cnt);
    assign w_wr_fire = r_run & wr_en & ~w_full;
    assign w_rd_fire = r_run & rd_en & ~w_empty;
    assign w_flush   = r_run & flush;

    // Next fill level: +1 per accepted write, -RATIO per accepted read
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_fire) w_count_nxt = w_count_nxt + c_cnt_w'(1);
        if (w_rd_fire) w_count_nxt = w_count_nxt - c_ratio_cnt;
    end

    // Pointer and count update; flush overrides any concurrent transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + c_ratio_ptr;
            if (w_wr_fire || w_rd_fire) r_count <= w_count_nxt;
        end
    end

    // Storage write: data plus even-parity bit (optionally corrupted)
    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_flush) begin
            r_mem[r_wr_ptr] <= {(^w_data) ^ par_inject, w_data};
        end
    end

    // ------------------------------------------------------------------------
    // Head word assembly: entry rd_ptr+k lands in lane k (oldest at LSB)
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < RATIO; k++) begin : g_head
        logic [ADDR_WIDTH-1:0] w_idx;
        logic [c_ent_w-1:0]    w_ent;
        assign w_idx = r_rd_ptr + ADDR_WIDTH'(k);
        assign w_ent = r_mem[w_idx];
        assign w_head[k*DATA_WIDTH +: DATA_WIDTH] = w_ent[DATA_WIDTH-1:0];
        // Stored entry has even parity overall when intact
        assign w_head_perr[k] = ^w_ent;
    end

    assign w_parity_error = ~w_empty & (|w_head_perr);

    // ------------------------------------------------------------------------
    // Sticky error flags; a set event beats err_clr in the same cycle
    // ------------------------------------------------------------------------
    assign w_ovf_set = r_run & wr_en & w_full;
    assign w_unf_set = r_run & rd_en & w_empty;
    assign w_par_set = w_rd_fire & w_parity_error;

    // Sticky flag registers, written only on a set or clear event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_parity_sticky <= 1'b0;
        end else begin
            if (w_ovf_set || err_clr) r_overflow      <= w_ovf_set;
            if (w_unf_set || err_clr) r_underflow     <= w_unf_set;
            if (w_par_set || err_clr) r_parity_sticky <= w_par_set;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; every flag is combinational from the current count
    // ------------------------------------------------------------------------
    assign full          = w_full;
    assign empty         = w_empty;
    assign almost_full   = (int'(r_count) >= AF_THRESH);
    assign almost_empty  = (int'(r_count) <  AE_THRESH);
    assign count         = r_count;
    assign r_data        = w_empty ? '0 : w_head;
    assign parity_error  = w_parity_error;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
    assign parity_sticky = r_parity_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fifo_upsize_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_upsize_wide
// Function : Self-checking bench for fifo_upsize_wide (default parameters).
//            Stimulus pushes expected wide words into a scoreboard; a
//            negedge monitor compares the presented head word against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_upsize_wide;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  w_data;
    logic        wr_en;
    logic        par_inject;
    logic        full;
    logic        almost_full;
    logic [31:0] r_data;
    logic        rd_en;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  count;
    logic        parity_error;
    logic        flush;
    logic        err_clr;
    logic        overflow;
    logic        underflow;
    logic        parity_sticky;

    typedef struct {
        logic [31:0] d;
        logic        p;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mcount   = 0;
    int          accn     = 0;
    logic [31:0] acc      = '0;
    logic        accp     = 1'b0;

    always #5 clk = ~clk;

    fifo_upsize_wide dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_data       (w_data),
        .wr_en        (wr_en),
        .par_inject   (par_inject),
        .full         (full),
        .almost_full  (almost_full),
        .r_data       (r_data),
        .rd_en        (rd_en),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .parity_error (parity_error),
        .flush        (flush),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
        .parity_sticky(parity_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model updates after the edge so the
    // monitor still sees the pre-edge scoreboard at the preceding negedge.
    task automatic cyc(input logic wr, input logic [7:0] b, input logic inj,
                       input logic rd, input logic fl, input logic ec);
        logic wf, rf;
        wr_en = wr; w_data = b; par_inject = inj;
        rd_en = rd; flush = fl; err_clr = ec;
        wf = wr && (mcount < 16);
        rf = rd && (mcount >= 4);
        @(posedge clk);
        if (fl) begin
            mcount = 0; accn = 0; accp = 1'b0; sb.delete();
        end else begin
            if (rf) mcount -= 4;
            if (wf) begin
                mcount++;
                acc[accn*8 +: 8] = b;
                accp = accp | inj;
                accn++;
                if (accn == 4) begin
                    sb.push_back('{acc, accp});
                    accn = 0;
                    accp = 1'b0;
                end
            end
        end
        #1;
        wr_en = 1'b0; w_data = '0; par_inject = 1'b0;
        rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b, input logic inj);
        cyc(1'b1, b, inj, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, {27'd0, count}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_ae"}, {31'd0, almost_empty}, 32'd1);
        chk({tag, "_af"}, {31'd0, almost_full}, 32'd0);
        chk({tag, "_rdata"}, r_data, 32'd0);
        chk({tag, "_perr"}, {31'd0, parity_error}, 32'd0);
        chk({tag, "_flags"}, {29'd0, overflow, underflow, parity_sticky}, 32'd0);
    endtask

    // Monitor: whenever a head word is presented, compare it with the
    // oldest expected word; retire it when the read is taken.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && empty === 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL head_unexpected: got 0x%0h expected no word", r_data);
            end else begin
                chk("head_data", r_data, sb[0].d);
                chk("head_perr", {31'd0, parity_error}, {31'd0, sb[0].p});
                if (rd_en && !flush) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; w_data = '0; par_inject = 1'b0;
        rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle();

        // Basic word assembly and read
        wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0);
        chk("partial_count", {27'd0, count}, 32'd3);
        chk("partial_empty", {31'd0, empty}, 32'd1);
        wr(8'h44, 1'b0);
        chk("word_count", {27'd0, count}, 32'd4);
        chk("word_empty", {31'd0, empty}, 32'd0);
        chk("word_rdata", r_data, 32'h4433_2211);
        chk("word_perr", {31'd0, parity_error}, 32'd0);
        chk("word_ae", {31'd0, almost_empty}, 32'd0);
        rd();
        chk("read_count", {27'd0, count}, 32'd0);
        chk("read_empty", {31'd0, empty}, 32'd1);

        // Fill past capacity
        for (int i = 0; i < 18; i++) wr(8'hA0 + 8'(i), 1'b0);
        chk("fill_count", {27'd0, count}, 32'd16);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_af", {31'd0, almost_full}, 32'd1);
        chk("fill_ovf", {31'd0, overflow}, 32'd1);
        idle();
        chk("ovf_held", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Simultaneous read/write at full and mid level, then flush
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rw_full_count", {27'd0, count}, 32'd12);
        chk("rw_full_full", {31'd0, full}, 32'd0);
        chk("af_at_12", {31'd0, almost_full}, 32'd1);
        rd();
        chk("af_at_8", {31'd0, almost_full}, 32'd0);
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rw_mid_count", {27'd0, count}, 32'd5);
        chk("ae_at_5", {31'd0, almost_empty}, 32'd0);
        wr(8'h56, 1'b0); wr(8'h57, 1'b0);
        chk("pre_flush_count", {27'd0, count}, 32'd7);
        cyc(1'b1, 8'h58, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_count", {27'd0, count}, 32'd0);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("no_underflow_yet", {31'd0, underflow}, 32'd0);

        // Pointer wrap
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        rd(); rd(); rd();
        chk("wrap_mid_count", {27'd0, count}, 32'd4);
        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b0);
        chk("wrap_fill_count", {27'd0, count}, 32'd12);
        rd(); rd();
        chk("wrap_ae_count", {27'd0, count}, 32'd4);
        rd();
        chk("wrap_end_count", {27'd0, count}, 32'd0);

        // Parity injection on byte 2 of the first word
        wr(8'h01, 1'b0); wr(8'h02, 1'b0); wr(8'h03, 1'b1); wr(8'h04, 1'b0);
        for (int i = 5; i < 9; i++) wr(8'(i), 1'b0);
        chk("perr_head", {31'd0, parity_error}, 32'd1);
        rd();
        chk("perr_sticky", {31'd0, parity_sticky}, 32'd1);
        chk("perr_clean_next", {31'd0, parity_error}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("perr_sticky_clr", {31'd0, parity_sticky}, 32'd0);
        rd();

        // Underflow, set-beats-clear
        rd();
        chk("unf_set", {31'd0, underflow}, 32'd1);
        chk("unf_count", {27'd0, count}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("unf_set_wins", {31'd0, underflow}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("unf_clr", {31'd0, underflow}, 32'd0);
        rd();

        // Asynchronous reset mid-fill
        for (int i = 0; i < 6; i++) wr(8'h90 + 8'(i), 1'b0);
        chk("prereset_count", {27'd0, count}, 32'd6);
        #1 rst_n = 1'b0;
        mcount = 0; accn = 0; accp = 1'b0; sb.delete();
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle();
        wr(8'hC1, 1'b0); wr(8'hC2, 1'b0); wr(8'hC3, 1'b0); wr(8'hC4, 1'b0);
        chk("post_reset_rdata", r_data, 32'hC4C3_C2C1);
        rd();
        chk("post_reset_count", {27'd0, count}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
